shift_sequencer: RTL and testbench

//  Multi-cycle controller for the 32-bit shift path. It accepts one shift request
//  (data, shift amount, op) and applies one power-of-two shift layer per clock,

---
 rtl/alu_shift_pkg.sv | 16 +
 rtl/shift_layer.sv | 35 +++
 rtl/shift_sequencer.sv | 112 +++++++++++
 tb/tb_shift_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the multi-cycle shift path:
// shift op encodings and the sequencer FSM states.
package alu_shift_pkg;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_layer.sv
// One power-of-two shift layer: shifts data by 2^layer_i per op,
// or passes it through unchanged when en_i is low.
module shift_layer
    import alu_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int LW      = $clog2(SHAMT_W)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [LW-1:0]    layer_i,
    input  logic             en_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] data_o
);

    logic [SHAMT_W:0] amt;
    logic [SHAMT_W:0] inv;

    always_comb begin
        amt    = (SHAMT_W+1)'(1) << layer_i;
        inv    = (SHAMT_W+1)'(WIDTH) - amt;
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                SH_SLL:  data_o = data_i << amt;
                SH_SRL:  data_o = data_i >> amt;
                SH_SRA:  data_o = WIDTH'($signed(data_i) >>> amt);
                SH_ROR:  data_o = (data_i >> amt) | (data_i << inv);
                default: data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: applies one shift layer per clock through a
// single shared shift_layer, exiting early once no higher shamt bits remain.
module shift_sequencer
    import alu_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               busy
);

    localparam int CNT_W = $clog2(SHAMT_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SHAMT_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic               zero_q, zero_d;

    logic [WIDTH-1:0]   layer_out;
    logic [SHAMT_W-1:0] hi_bits;
    logic               hi_zero;

    shift_layer #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .LW      (CNT_W)
    ) u_layer (
        .data_i  (data_q),
        .layer_i (cnt_q),
        .en_i    (shamt_q[cnt_q]),
        .op_i    (op_q),
        .data_o  (layer_out)
    );

    // Amount bits strictly above the current layer
    assign hi_bits = (shamt_q >> cnt_q) >> 1;
    assign hi_zero = (hi_bits == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= SH_SLL;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    shamt_d = in_shamt;
                    op_d    = in_op;
                    cnt_d   = '0;
                    zero_d  = (in_data == '0);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = layer_out;
                zero_d = (layer_out == '0);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST || hi_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = data_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed vector bench for shift_sequencer: table of ops plus
// hand sequences for backpressure and mid-operation reset.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Present one request in IDLE; returns after the accepting edge
    task automatic start_op(input logic [1:0] op, input logic [31:0] d,
                            input logic [4:0] sh);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("in_ready before start", {31'b0, in_ready}, 32'd1);
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid is seen
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            lat++;
            if (k > 0 || !out_valid) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (out_valid) break;
        end
        if (!out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: out_valid never rose, want 1");
        end
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " in_ready after take"}, {31'b0, in_ready}, 32'd1);
        check({name, " out_valid after take"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int    lat;
        string nm;

        vecs[0]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5};
        vecs[1]  = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 3};
        vecs[2]  = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 3};
        vecs[3]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[4]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[5]  = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[6]  = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[7]  = '{2'b00, 32'h8000_0000, 5'd1,  32'h0000_0000, 1};
        vecs[8]  = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 1};
        vecs[9]  = '{2'b11, 32'h1234_5678, 5'd16, 32'h5678_1234, 5};
        vecs[10] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5};
        vecs[11] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 5};
        vecs[12] = '{2'b01, 32'hF000_0000, 5'd5,  32'h0780_0000, 3};
        vecs[13] = '{2'b11, 32'h0000_00F0, 5'd8,  32'hF000_0000, 4};
        vecs[14] = '{2'b00, 32'h0000_0003, 5'd10, 32'h0000_0C00, 4};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_data", out_data, 32'h0);
        check("reset out_zero", {31'b0, out_zero}, 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            nm = $sformatf("v%0d", i);
            start_op(vecs[i].op, vecs[i].data, vecs[i].shamt);
            wait_done(lat);
            check({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
            check({nm, " out_data"}, out_data, vecs[i].exp);
            check({nm, " out_zero"}, {31'b0, out_zero},
                  {31'b0, vecs[i].exp == 32'h0});
            release_out(nm);
        end

        // Backpressure: hold DONE for 3 cycles with stray requests
        start_op(2'b00, 32'h0000_0001, 5'd2);
        wait_done(lat);
        check("bp latency", 32'(lat), 32'd2);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hFFFF_0000 + 32'(c);
            in_shamt = 5'd3;
            @(posedge clk);
            @(negedge clk);
            check("bp out_valid", {31'b0, out_valid}, 32'd1);
            check("bp out_data", out_data, 32'h0000_0004);
            check("bp busy", {31'b0, busy}, 32'd1);
            check("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp in_ready after take", {31'b0, in_ready}, 32'd1);
        check("bp out_valid after take", {31'b0, out_valid}, 32'd0);
        check("bp out_data held", out_data, 32'h0000_0004);

        // Reset on the second SHIFT cycle of a shamt=31 op
        start_op(2'b00, 32'h0000_0001, 5'd31);
        @(posedge clk);
        @(negedge clk);
        check("abort busy before reset", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort in_ready", {31'b0, in_ready}, 32'd1);
        check("abort out_data", out_data, 32'h0);
        start_op(2'b00, 32'h0000_0001, 5'd2);
        wait_done(lat);
        check("post-abort latency", 32'(lat), 32'd2);
        check("post-abort out_data", out_data, 32'h0000_0004);
        release_out("post-abort");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
